// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the req/ack bundled-data CDC source controller.
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      HS_IDLE = 2'd0,
      HS_REQ  = 2'd1,
      HS_REL  = 2'd2
   } hs_state_e;

   function automatic int to_cnt_w(input int cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/two_ff_sync.sv
// Two-flop synchronizer for single-bit (or independent) signals entering the clk domain.
module two_ff_sync #(
   parameter int SIZE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] q
);

   logic [SIZE-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a 4-phase req/ack bundled-data crossing. Define CDC_HS_TIMEOUT_EN
// to add a per-phase watchdog with a sticky timeout_err flag.
module cdc_hs_tx_ctrl
   import cdc_hs_pkg::*;
#(
   parameter int DATA_W = 32
`ifdef CDC_HS_TIMEOUT_EN
 , parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic [DATA_W-1:0] x_data,
   output logic              x_req,
   input  logic              x_ack,
   output logic              busy,
   output logic              done_pulse
`ifdef CDC_HS_TIMEOUT_EN
 , output logic              timeout_err,
   input  logic              err_clr
`endif
);

   hs_state_e state_q, state_d;
   logic      ack_s;
   logic      x_req_d;
   logic      load;
   logic      done_d;

   two_ff_sync #(.SIZE(1)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (x_ack),
      .q     (ack_s)
   );

   // A stale ack seen while idle blocks new words until the far side releases it.
   assign s_ready = (state_q == HS_IDLE) && !ack_s;
   assign busy    = (state_q != HS_IDLE);

`ifdef CDC_HS_TIMEOUT_EN
   localparam int              CNT_W   = to_cnt_w(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             tmo_hit;
   logic             tmo_set;
   logic             tmo_seen_q;

   assign tmo_hit = (cnt_q == CNT_MAX);
`endif

   always_comb begin
      state_d = state_q;
      x_req_d = x_req;
      load    = 1'b0;
      done_d  = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      tmo_set = 1'b0;
`endif
      case (state_q)
         HS_IDLE: begin
            if (s_valid && s_ready) begin
               load    = 1'b1;
               x_req_d = 1'b1;
               state_d = HS_REQ;
            end
         end
         HS_REQ: begin
            if (ack_s) begin
               x_req_d = 1'b0;
               state_d = HS_REL;
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (tmo_hit) begin
               x_req_d = 1'b0;
               state_d = HS_REL;
               tmo_set = 1'b1;
            end
`endif
         end
         HS_REL: begin
            if (!ack_s) begin
               state_d = HS_IDLE;
`ifdef CDC_HS_TIMEOUT_EN
               done_d  = !tmo_seen_q;
`else
               done_d  = 1'b1;
`endif
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d = HS_IDLE;
               tmo_set = 1'b1;
            end
`endif
         end
         default: begin
            state_d = HS_IDLE;
            x_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HS_IDLE;
         x_req      <= 1'b0;
         x_data     <= '0;
         done_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_req      <= x_req_d;
         done_pulse <= done_d;
         if (load) begin
            x_data <= s_data;
         end
      end
   end

`ifdef CDC_HS_TIMEOUT_EN
   // Timeout set has priority over err_clr so a fresh failure is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         tmo_seen_q  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if ((state_d != state_q) || (state_q == HS_IDLE)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (state_d == HS_IDLE) begin
            tmo_seen_q <= 1'b0;
         end else if (tmo_set) begin
            tmo_seen_q <= 1'b1;
         end

         if (tmo_set) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Directed bench for cdc_hs_tx_ctrl; exercises the timeout path when CDC_HS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cdc_hs_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [31:0] x_data;
   logic        x_req;
   logic        x_ack;
   logic        busy;
   logic        done_pulse;
`ifdef CDC_HS_TIMEOUT_EN
   logic        timeout_err;
   logic        err_clr;
`endif

   int          n_chk = 0;
   int          n_err = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   int          viol = 0;
   int          ack_low = 0;
   logic        xreq_prev = 1'b0;
   logic [31:0] rise_q[$];
   bit          stall_mode = 1'b0;
   logic [31:0] stall_word = '0;

   always #5 clk = ~clk;

   cdc_hs_tx_ctrl #(
      .DATA_W      (32)
`ifdef CDC_HS_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .x_data      (x_data),
      .x_req       (x_req),
      .x_ack       (x_ack),
      .busy        (busy),
      .done_pulse  (done_pulse)
`ifdef CDC_HS_TIMEOUT_EN
    , .timeout_err (timeout_err),
      .err_clr     (err_clr)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Post-edge observation of each clock edge; the next edge sees the same inputs.
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_valid && s_ready) acc_cnt++;
         if (done_pulse) done_cnt++;
         if (x_req && !xreq_prev) begin
            rise_q.push_back(x_data);
            if (ack_low < 3) viol++;
         end
         xreq_prev = x_req;
         ack_low   = x_ack ? 0 : ack_low + 1;
      end else begin
         xreq_prev = 1'b0;
      end
   end

   task automatic tick;
      if (stall_mode) begin
         s_valid = ~s_valid;
         s_data  = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      if (stall_mode && busy) begin
         chk("stall_ready", s_ready, 1'b0);
         chk("stall_data", x_data, stall_word);
      end
   endtask

   task automatic wait_xreq(input logic lvl, input string tag);
      int n = 0;
      while (x_req !== lvl && n < 64) begin
         tick();
         n++;
      end
      chk(tag, x_req, lvl);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_pulse !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      chk(tag, done_pulse, 1'b1);
   endtask

   task automatic handshake;
      tick();
      tick();
      x_ack = 1'b1;
      wait_xreq(1'b0, "hs_req_fall");
      x_ack = 1'b0;
      wait_done("hs_done");
   endtask

   task automatic clear_counts;
      acc_cnt  = 0;
      done_cnt = 0;
      viol     = 0;
      rise_q.delete();
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      x_ack   = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      err_clr = 1'b0;
`endif
      #12;
      chk("rst_x_req", x_req, 1'b0);
      chk("rst_x_data", x_data, 32'h0);
      chk("rst_done", done_pulse, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("rst_ready", s_ready, 1'b1);

      // Single word
      clear_counts();
      s_data  = 32'hA5A5_0001;
      s_valid = 1'b1;
      chk("t1_ready", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      chk("t1_req_rise", x_req, 1'b1);
      chk("t1_data", x_data, 32'hA5A5_0001);
      chk("t1_busy", busy, 1'b1);
      chk("t1_ready_busy", s_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_req_hold", x_req, 1'b1);
      end
      x_ack = 1'b1;
      tick();
      chk("t1_req_e1", x_req, 1'b1);
      tick();
      chk("t1_req_e2", x_req, 1'b1);
      tick();
      chk("t1_req_e3", x_req, 1'b0);
      chk("t1_rel_busy", busy, 1'b1);
      x_ack = 1'b0;
      tick();
      chk("t1_done_e1", done_pulse, 1'b0);
      tick();
      chk("t1_done_e2", done_pulse, 1'b0);
      tick();
      chk("t1_done_e3", done_pulse, 1'b1);
      chk("t1_idle", busy, 1'b0);
      chk("t1_ready_back", s_ready, 1'b1);
      tick();
      chk("t1_done_once", done_pulse, 1'b0);
      chk("t1_data_kept", x_data, 32'hA5A5_0001);
      chk("t1_done_cnt", done_cnt, 1);

      // Back-to-back with s_valid held high
      clear_counts();
      s_data  = 32'd1;
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_xreq(1'b1, "t2_req_rise");
         if (i == 2) s_valid = 1'b0;
         else        s_data  = 32'(i + 2);
         handshake();
      end
      repeat (4) tick();
      chk("t2_accepts", acc_cnt, 3);
      chk("t2_dones", done_cnt, 3);
      chk("t2_rises", rise_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < rise_q.size()) chk("t2_word", rise_q[i], 32'(i + 1));
      end
      chk("t2_req_after_ack_low", viol, 0);

      // Busy stall
      clear_counts();
      stall_word = 32'h1111_2222;
      s_data     = stall_word;
      s_valid    = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("t3_req", x_req, 1'b1);
      stall_mode = 1'b1;
      handshake();
      stall_mode = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      repeat (3) tick();
      chk("t3_accepts", acc_cnt, 1);
      chk("t3_dones", done_cnt, 1);
      chk("t3_req_idle", x_req, 1'b0);
      chk("t3_data_kept", x_data, 32'h1111_2222);

      // Reset in HS_REQ with x_ack held high
      clear_counts();
      s_data  = 32'hCAFE_0004;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("t4_req", x_req, 1'b1);
      x_ack = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_req", x_req, 1'b0);
      chk("t4_rst_data", x_data, 32'h0);
      chk("t4_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("t4_stale_ready", s_ready, 1'b0);
      s_valid = 1'b1;
      tick();
      tick();
      chk("t4_no_accept", x_req, 1'b0);
      chk("t4_stale_ready2", s_ready, 1'b0);
      x_ack = 1'b0;
      tick();
      chk("t4_ready_e1", s_ready, 1'b0);
      tick();
      chk("t4_ready_e2", s_ready, 1'b1);
      s_valid = 1'b0;
      tick();
      chk("t4_no_done", done_cnt, 0);

`ifdef CDC_HS_TIMEOUT_EN
      // Timeout with x_ack tied low
      begin
         int n = 0;
         clear_counts();
         s_data  = 32'h0000_0005;
         s_valid = 1'b1;
         tick();
         s_valid = 1'b0;
         chk("t5_req", x_req, 1'b1);
         while (x_req === 1'b1 && n < 64) begin
            tick();
            n++;
         end
         chk("t5_req_cycles", n, 16);
         chk("t5_err", timeout_err, 1'b1);
         chk("t5_rel_busy", busy, 1'b1);
         tick();
         chk("t5_idle", busy, 1'b0);
         chk("t5_err_sticky", timeout_err, 1'b1);
         chk("t5_no_done", done_cnt, 0);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         chk("t5_err_clr", timeout_err, 1'b0);
      end
`else
      // No timeout: handshake waits indefinitely
      clear_counts();
      s_data  = 32'h0000_0006;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (10000) tick();
      chk("t6_req_held", x_req, 1'b1);
      chk("t6_busy", busy, 1'b1);
      chk("t6_no_done", done_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
